// File: rtl/mem_test_checker.sv
// mem_test_checker: scoreboard that checks memory reads against the last written word.
// It snoops the generator bus and reports the error count, the first failing address and pass/fail.
module mem_test_checker #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chip_sel,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              clear,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  cmp_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_pulse,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic cs_q, rise, start, active, push, proto_err, cmp_vld, cmp_err, exp_valid;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [RD_LAT-1:0] p_v;
    logic [ADDR_W-1:0] p_addr [RD_LAT];
    logic [DATA_W-1:0] p_data [RD_LAT];
    logic [1:0]        err_inc;
    logic [CNT_W:0]    err_sum;
    logic [CNT_W-1:0]  err_next, cmp_next;

    assign rise      = chip_sel && !cs_q;
    assign start     = (state == IDLE || state == DONE) && rise && !clear;
    assign active    = state == RUN || state == DRAIN;
    // Only a clean read of the single tracked address enters the pipe; anything else is a protocol error.
    assign push      = state == RUN && rd_en && !wr_en && exp_valid && address == exp_addr;
    assign proto_err = state == RUN && rd_en && !push;
    assign cmp_vld   = p_v[RD_LAT-1];
    assign cmp_err   = cmp_vld && rd_data != p_data[RD_LAT-1];
    assign err_inc   = {1'b0, proto_err} + {1'b0, cmp_err};
    assign err_sum   = {1'b0, err_count} + (CNT_W+1)'(err_inc);
    assign err_next  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    assign cmp_next  = &cmp_count ? cmp_count : cmp_count + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: if (rise) state_nx = RUN;
            RUN:        if (!chip_sel) state_nx = DRAIN;
            DRAIN:      if (p_v == '0) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    always_comb begin
        busy = active;
        done = state == DONE;
        pass = state == DONE && err_count == '0 && cmp_count != '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q            <= 1'b0;
            exp_valid       <= 1'b0;
            exp_addr        <= '0;
            exp_data        <= '0;
            p_v             <= '0;
            cmp_count       <= '0;
            err_count       <= '0;
            err_pulse       <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else begin
            cs_q <= chip_sel;
            if (clear || start) begin
                exp_valid       <= 1'b0;
                p_v             <= '0;
                cmp_count       <= '0;
                err_count       <= '0;
                err_pulse       <= 1'b0;
                first_err_valid <= 1'b0;
                first_err_addr  <= '0;
            end else begin
                if (active && wr_en) begin
                    exp_valid <= 1'b1;
                    exp_addr  <= address;
                    exp_data  <= wr_data;
                end
                for (int i = RD_LAT - 1; i > 0; i--) p_v[i] <= p_v[i-1];
                p_v[0] <= push;
                if (cmp_vld) cmp_count <= cmp_next;
                err_pulse <= proto_err || cmp_err;
                if (proto_err || cmp_err) begin
                    err_count <= err_next;
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_addr  <= cmp_err ? p_addr[RD_LAT-1] : address;
                    end
                end
            end
        end
    end

    // Payload shifts unconditionally; validity lives only in p_v.
    always_ff @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
            p_addr[i] <= p_addr[i-1];
            p_data[i] <= p_data[i-1];
        end
        p_addr[0] <= address;
        p_data[0] <= exp_data;
    end
endmodule

// File: tb/tb_mem_test_checker.sv
// tb_mem_test_checker: checks three checker instances (RD_LAT=1, RD_LAT=3, CNT_W=4) on a shared bus.
module tb_mem_test_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, chip_sel = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clear = 1'b0;
    logic [10:0] address = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] mem [2048];
    logic [15:0] s1, r3a, r3b;
    int flip_a = -1, flip_b = -1;
    bit corrupt_all = 1'b0;
    int total = 0, bad = 0;
    int exp_q[$];
    int exp_err = 0, e_head;
    bit mon_en = 1'b0;

    logic busy1, done1, pass1, ep1, fev1;
    logic [11:0] cmp1, ec1;
    logic [10:0] fea1;
    logic busy3, done3, pass3, ep3, fev3;
    logic [11:0] cmp3, ec3;
    logic [10:0] fea3;
    logic busy4, done4, pass4, ep4, fev4;
    logic [3:0] cmp4, ec4;
    logic [10:0] fea4;

    mem_test_checker u1 (.clk(clk), .reset(reset), .chip_sel(chip_sel), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .wr_data(wr_data), .rd_data(s1), .clear(clear), .busy(busy1), .done(done1),
        .pass(pass1), .cmp_count(cmp1), .err_count(ec1), .err_pulse(ep1), .first_err_valid(fev1),
        .first_err_addr(fea1));
    mem_test_checker #(.RD_LAT(3)) u3 (.clk(clk), .reset(reset), .chip_sel(chip_sel), .wr_en(wr_en),
        .rd_en(rd_en), .address(address), .wr_data(wr_data), .rd_data(r3b), .clear(clear), .busy(busy3),
        .done(done3), .pass(pass3), .cmp_count(cmp3), .err_count(ec3), .err_pulse(ep3),
        .first_err_valid(fev3), .first_err_addr(fea3));
    mem_test_checker #(.CNT_W(4)) u4 (.clk(clk), .reset(reset), .chip_sel(chip_sel), .wr_en(wr_en),
        .rd_en(rd_en), .address(address), .wr_data(wr_data), .rd_data(s1), .clear(clear), .busy(busy4),
        .done(done4), .pass(pass4), .cmp_count(cmp4), .err_count(ec4), .err_pulse(ep4),
        .first_err_valid(fev4), .first_err_addr(fea4));

    function automatic bit flipped(int a);
        return corrupt_all || a == flip_a || a == flip_b;
    endfunction

    function automatic logic [15:0] pat(int a);
        return 16'((a * 37) ^ 16'hA5C3);
    endfunction

    // Synchronous memory model: 1-cycle read into s1, two extra stages for the RD_LAT=3 instance.
    always @(posedge clk) begin
        if (wr_en) mem[address] <= wr_data;
        if (rd_en) s1 <= mem[address] ^ (flipped(int'(address)) ? 16'h0001 : 16'h0000);
        r3a <= s1;
        r3b <= r3a;
    end

    // Each err_pulse of u1 retires one expected cumulative error count.
    always @(negedge clk) begin
        if (mon_en && ep1 === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL err_pulse_unexpected got=1 exp=0 ec=%0d", ec1);
            end else begin
                e_head = exp_q.pop_front();
                if (ec1 !== 12'(e_head)) begin
                    bad++;
                    $display("FAIL err_pulse_count got=%0d exp=%0d", ec1, e_head);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int n);
        exp_err = 0;
        chip_sel = 1'b1;
        cyc();
        for (int a = 0; a < n; a++) begin
            address = 11'(a);
            wr_data = pat(a);
            wr_en = 1'b1;
            cyc();
            wr_en = 1'b0;
            rd_en = 1'b1;
            if (mon_en && flipped(a)) begin
                exp_err++;
                exp_q.push_back(exp_err);
            end
            cyc();
            rd_en = 1'b0;
        end
        chip_sel = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!(done1 && done3 && done4) && k < 100) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (!(done1 && done3 && done4)) begin
            bad++;
            $display("FAIL done_timeout got=%b%b%b exp=111", done1, done3, done4);
        end
    endtask

    task automatic check_queue(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending_errs got=%0d exp=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy1, done1, pass1, ep1, fev1} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000", {busy1, done1, pass1, ep1, fev1});
        end
        total++;
        if ({cmp1, ec1, fea1} !== 35'b0) begin
            bad++;
            $display("FAIL reset_vals got=%0d/%0d/%0d exp=0/0/0", cmp1, ec1, fea1);
        end
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_full_sweep();
        mon_en = 1'b1;
        sweep(2048);
        wait_done();
        total++;
        if (cmp1 !== 12'd2048) begin bad++; $display("FAIL full_cmp got=%0d exp=2048", cmp1); end
        total++;
        if (ec1 !== 12'd0) begin bad++; $display("FAIL full_err got=%0d exp=0", ec1); end
        total++;
        if (pass1 !== 1'b1 || fev1 !== 1'b0) begin
            bad++; $display("FAIL full_pass got=%b/%b exp=1/0", pass1, fev1);
        end
        check_queue("full");
    endtask

    task automatic test_bit_flips();
        flip_a = 5;
        flip_b = 9;
        sweep(16);
        wait_done();
        total++;
        if (ec1 !== 12'd2) begin bad++; $display("FAIL flip_err got=%0d exp=2", ec1); end
        total++;
        if (fea1 !== 11'd5 || fev1 !== 1'b1) begin
            bad++; $display("FAIL flip_first got=%0d/%b exp=5/1", fea1, fev1);
        end
        total++;
        if (pass1 !== 1'b0 || cmp1 !== 12'd16) begin
            bad++; $display("FAIL flip_pass got=%b/%0d exp=0/16", pass1, cmp1);
        end
        check_queue("flip");
        flip_a = -1;
        flip_b = -1;
    endtask

    task automatic test_drain_lat3();
        sweep(8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (busy3 !== 1'b1 || done3 !== 1'b0) begin
                bad++; $display("FAIL drain_busy%0d got=%b/%b exp=1/0", i, busy3, done3);
            end
        end
        wait_done();
        total++;
        if (cmp3 !== 12'd8 || ec3 !== 12'd0 || pass3 !== 1'b1) begin
            bad++; $display("FAIL drain_result got=%0d/%0d/%b exp=8/0/1", cmp3, ec3, pass3);
        end
        check_queue("drain");
    endtask

    task automatic test_protocol();
        exp_err = 0;
        chip_sel = 1'b1;
        cyc();
        address = 11'd7;
        rd_en = 1'b1;
        exp_q.push_back(1);
        cyc();
        address = 11'd3;
        wr_data = 16'h1234;
        wr_en = 1'b1;
        exp_q.push_back(2);
        cyc();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chip_sel = 1'b0;
        wait_done();
        total++;
        if (ec1 !== 12'd2 || cmp1 !== 12'd0) begin
            bad++; $display("FAIL proto_counts got=%0d/%0d exp=2/0", ec1, cmp1);
        end
        total++;
        if (fea1 !== 11'd7 || pass1 !== 1'b0) begin
            bad++; $display("FAIL proto_first got=%0d/%b exp=7/0", fea1, pass1);
        end
        check_queue("proto");
        mon_en = 1'b0;
    endtask

    task automatic test_saturate();
        corrupt_all = 1'b1;
        sweep(20);
        wait_done();
        corrupt_all = 1'b0;
        total++;
        if (ec4 !== 4'd15 || cmp4 !== 4'd15) begin
            bad++; $display("FAIL sat_counts got=%0d/%0d exp=15/15", ec4, cmp4);
        end
        total++;
        if (ec1 !== 12'd20 || pass4 !== 1'b0) begin
            bad++; $display("FAIL sat_wide got=%0d/%b exp=20/0", ec1, pass4);
        end
    endtask

    task automatic test_reset_mid_sweep();
        chip_sel = 1'b1;
        cyc();
        for (int a = 0; a < 3; a++) begin
            address = 11'(a);
            wr_data = pat(a);
            wr_en = 1'b1;
            cyc();
            wr_en = 1'b0;
            rd_en = 1'b1;
            cyc();
            rd_en = 1'b0;
        end
        corrupt_all = 1'b1;
        address = 11'd3;
        wr_data = pat(3);
        wr_en = 1'b1;
        cyc();
        wr_en = 1'b0;
        rd_en = 1'b1;
        cyc();
        reset = 1'b1;
        rd_en = 1'b0;
        chip_sel = 1'b0;
        @(negedge clk);
        total++;
        if ({busy1, done1, pass1, ep1, fev1} !== 5'b0 || cmp1 !== 12'd0 || ec1 !== 12'd0) begin
            bad++; $display("FAIL midreset_out got=%b/%0d/%0d exp=00000/0/0",
                            {busy1, done1, pass1, ep1, fev1}, cmp1, ec1);
        end
        cyc();
        reset = 1'b0;
        corrupt_all = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (cmp1 !== 12'd0 || ec1 !== 12'd0 || busy1 !== 1'b0) begin
            bad++; $display("FAIL midreset_stale got=%0d/%0d/%b exp=0/0/0", cmp1, ec1, busy1);
        end
        sweep(8);
        wait_done();
        total++;
        if (pass1 !== 1'b1 || cmp1 !== 12'd8) begin
            bad++; $display("FAIL resweep got=%b/%0d exp=1/8", pass1, cmp1);
        end
        cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        @(negedge clk);
        total++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || cmp1 !== 12'd0 || pass1 !== 1'b0) begin
            bad++; $display("FAIL clear got=%b/%b/%0d/%b exp=0/0/0/0", done1, busy1, cmp1, pass1);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        test_reset();
        test_full_sweep();
        test_bit_flips();
        test_drain_lat3();
        test_protocol();
        test_saturate();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
